// File: rtl/btle_rx_pdu_dewhiten_pkg.sv
// Shared constants and helpers for the BTLE receive PDU engine.
package btle_rx_pdu_dewhiten_pkg;

    localparam logic [23:0] CRC_POLY_MASK  = 24'h00065B;
    localparam logic [23:0] ADV_CRC_PRESET = 24'h555555;
    localparam int          HDR_BITS       = 16;
    localparam int          CRC_BITS       = 24;
    localparam int          WHITEN_W       = 7;

    // x^7+x^4+1 whitening LFSR, one step: w0<-w6, w4<-w3^w6, others shift up.
    function automatic logic [WHITEN_W-1:0] whiten_step(input logic [WHITEN_W-1:0] w);
        whiten_step = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
    endfunction

endpackage

// File: rtl/btle_rx_pdu_dewhiten_crc24_core.sv
// Bit-serial CRC register: load preset, shift one bit per update, hold while frozen.
module crc24_core #(
    parameter int          WIDTH = 24,
    parameter logic [WIDTH-1:0] POLY = 24'h00065B
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] init,
    input  logic             update_en,
    input  logic             freeze,
    input  logic             din,
    output logic [WIDTH-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (load) begin
            crc <= init;
        end else if (update_en && !freeze) begin
            crc <= {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

endmodule

// File: rtl/btle_rx_pdu_dewhiten.sv
// BTLE RX link-layer PDU engine: de-whiten, parse header length, pack octets, check CRC.
module btle_rx_pdu_dewhiten
    import btle_rx_pdu_dewhiten_pkg::*;
#(
    parameter int CHANNEL_NUMBER_BIT_WIDTH = 6,
    parameter int CRC_STATE_BIT_WIDTH      = 24
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [CHANNEL_NUMBER_BIT_WIDTH-1:0] channel_number,
    input  logic [CRC_STATE_BIT_WIDTH-1:0]      crc_state_init,
    input  logic                                start,
    input  logic                                bit_in,
    input  logic                                bit_in_valid,
    output logic                                bit_out,
    output logic                                bit_out_valid,
    output logic [7:0]                          octet_out,
    output logic                                octet_out_valid,
    output logic [7:0]                          payload_length,
    output logic                                payload_length_valid,
    output logic                                crc_ok,
    output logic                                packet_done,
    output logic                                busy
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CRC} state_t;

    state_t                         state_q, state_d;
    logic [WHITEN_W-1:0]            w_q, w_seed;
    logic [10:0]                    bit_cnt_q;
    logic [7:0]                     octet_sr_q, octet_sr_d;
    logic                           match_q;
    logic                           accept, d;
    logic                           hdr_last, pay_last, crc_last, crc_bit_ok, octet_last;
    logic [CRC_STATE_BIT_WIDTH-1:0] crc;

    // Channel index goes in bit-reversed: channel bit 5 lands in w[1], bit 0 in w[6].
    always_comb begin
        w_seed    = '0;
        w_seed[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w_seed[i+1] = channel_number[5-i];
        end
    end

    assign accept     = bit_in_valid && !start && (state_q != IDLE);
    assign d          = bit_in ^ w_q[6];
    assign octet_sr_d = {d, octet_sr_q[7:1]};

    assign hdr_last   = (state_q == HEADER)  && (bit_cnt_q == 11'(HDR_BITS - 1));
    assign pay_last   = (state_q == PAYLOAD) && (bit_cnt_q == ({payload_length, 3'b000} - 11'd1));
    assign crc_last   = (state_q == CRC)     && (bit_cnt_q == 11'(CRC_BITS - 1));
    assign octet_last = ((state_q == HEADER) || (state_q == PAYLOAD)) && (bit_cnt_q[2:0] == 3'd7);
    // The CRC register is frozen during the trailer, so index it MSB-first by bit count.
    assign crc_bit_ok = (d == crc[5'(CRC_BITS - 1) - bit_cnt_q[4:0]]);

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = HEADER;
        end else if (accept) begin
            case (state_q)
                HEADER:  if (hdr_last) state_d = (octet_sr_d != 8'd0) ? PAYLOAD : CRC;
                PAYLOAD: if (pay_last) state_d = CRC;
                CRC:     if (crc_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q                  <= 7'b0000001;
            bit_cnt_q            <= '0;
            octet_sr_q           <= '0;
            match_q              <= 1'b0;
            bit_out              <= 1'b0;
            bit_out_valid        <= 1'b0;
            octet_out            <= '0;
            octet_out_valid      <= 1'b0;
            payload_length       <= '0;
            payload_length_valid <= 1'b0;
            crc_ok               <= 1'b0;
            packet_done          <= 1'b0;
        end else begin
            bit_out_valid   <= accept;
            octet_out_valid <= accept && octet_last;
            packet_done     <= accept && crc_last;
            if (accept) begin
                bit_out <= d;
            end
            if (accept && octet_last) begin
                octet_out <= octet_sr_d;
            end

            if (start) begin
                w_q                  <= w_seed;
                bit_cnt_q            <= '0;
                payload_length_valid <= 1'b0;
                crc_ok               <= 1'b0;
                match_q              <= 1'b1;
            end else if (accept) begin
                w_q        <= whiten_step(w_q);
                octet_sr_q <= octet_sr_d;
                bit_cnt_q  <= (state_d != state_q) ? 11'd0 : bit_cnt_q + 11'd1;
                if (hdr_last) begin
                    payload_length       <= octet_sr_d;
                    payload_length_valid <= 1'b1;
                end
                if (state_q == CRC) begin
                    match_q <= match_q && crc_bit_ok;
                    if (crc_last) begin
                        crc_ok <= match_q && crc_bit_ok;
                    end
                end
            end
        end
    end

    crc24_core #(
        .WIDTH (CRC_STATE_BIT_WIDTH),
        .POLY  (CRC_STATE_BIT_WIDTH'(CRC_POLY_MASK))
    ) u_crc (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (start),
        .init      (crc_state_init),
        .update_en (accept && ((state_q == HEADER) || (state_q == PAYLOAD))),
        .freeze    (state_q == CRC),
        .din       (d),
        .crc       (crc)
    );

endmodule

// File: tb/tb_btle_rx_pdu_dewhiten.sv
// Directed bench for btle_rx_pdu_dewhiten: whitening vectors plus full packets built by a reference model.
module tb_btle_rx_pdu_dewhiten;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  channel_number;
    logic [23:0] crc_state_init;
    logic        start, bit_in, bit_in_valid;
    logic        bit_out, bit_out_valid;
    logic [7:0]  octet_out;
    logic        octet_out_valid;
    logic [7:0]  payload_length;
    logic        payload_length_valid;
    logic        crc_ok, packet_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic       bitq[$];
    logic [7:0] pdu[$];
    logic [7:0] oct_q[$];
    int         done_cnt = 0;

    typedef struct {
        logic       do_start;
        logic [5:0] ch;
        logic       b;
        logic       exp_out;
    } vec_t;
    vec_t tv[15];

    always #5 clk = ~clk;

    btle_rx_pdu_dewhiten dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .channel_number       (channel_number),
        .crc_state_init       (crc_state_init),
        .start                (start),
        .bit_in               (bit_in),
        .bit_in_valid         (bit_in_valid),
        .bit_out              (bit_out),
        .bit_out_valid        (bit_out_valid),
        .octet_out            (octet_out),
        .octet_out_valid      (octet_out_valid),
        .payload_length       (payload_length),
        .payload_length_valid (payload_length_valid),
        .crc_ok               (crc_ok),
        .packet_done          (packet_done),
        .busy                 (busy)
    );

    always @(negedge clk) begin
        if (octet_out_valid) oct_q.push_back(octet_out);
        if (packet_done) done_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [5:0] ch);
        channel_number = ch;
        crc_state_init = 24'h555555;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    // Reference transmitter: CRC over pdu, append CRC MSB first, optional bit flip, whiten.
    task automatic build(input logic [5:0] ch, input int flip);
        logic        raw[$];
        logic [23:0] c;
        logic [6:0]  w;
        logic        fb;
        raw = {};
        bitq = {};
        foreach (pdu[i]) for (int j = 0; j < 8; j++) raw.push_back(pdu[i][j]);
        c = 24'h555555;
        foreach (raw[i]) begin
            fb = raw[i] ^ c[23];
            c  = c << 1;
            if (fb) c = c ^ 24'h00065B;
        end
        for (int k = 0; k < 24; k++) raw.push_back(c[23-k]);
        if (flip >= 0) raw[flip] = ~raw[flip];
        w = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
        foreach (raw[i]) begin
            bitq.push_back(raw[i] ^ w[6]);
            w = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
        end
    endtask

    task automatic send_pkt(input int gap, input logic [7:0] len);
        int n;
        n = bitq.size();
        for (int i = 0; i < n; i++) begin
            bit_in = bitq[i];
            bit_in_valid = 1'b1;
            tick;
            bit_in_valid = 1'b0;
            if (i == 14) check("plv_before_hdr_end", payload_length_valid, 1'b0);
            if (i == 15) begin
                check("plv_after_hdr", payload_length_valid, 1'b1);
                check("payload_length", payload_length, len);
            end
            if (i == n - 2) check("done_early", packet_done, 1'b0);
            if (i == n - 1) begin
                check("packet_done", packet_done, 1'b1);
                check("busy_fall", busy, 1'b0);
            end
            repeat (gap) tick;
        end
    endtask

    task automatic check_octets(input string name, input int base);
        check({name, "_count"}, oct_q.size() - base, pdu.size());
        for (int i = 0; i < pdu.size() && base + i < oct_q.size(); i++) begin
            if (oct_q[base+i] !== pdu[i]) check({name, "_octet"}, oct_q[base+i], pdu[i]);
        end
    endtask

    initial begin
        int ob, db;
        rst_n = 1'b0;
        channel_number = '0;
        crc_state_init = '0;
        start = 1'b0;
        bit_in = 1'b0;
        bit_in_valid = 1'b0;
        repeat (3) tick;

        check("rst_bit_out_valid", bit_out_valid, 1'b0);
        check("rst_octet_out", octet_out, 8'h00);
        check("rst_plv", payload_length_valid, 1'b0);
        check("rst_crc_ok", crc_ok, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", packet_done, 1'b0);
        rst_n = 1'b1;
        tick;

        // Whitening stream: channel 0 with zeros/ones, channel 37 with zeros
        tv[0]  = '{1'b1, 6'd0,  1'b0, 1'b0};
        tv[1]  = '{1'b0, 6'd0,  1'b0, 1'b0};
        tv[2]  = '{1'b0, 6'd0,  1'b0, 1'b0};
        tv[3]  = '{1'b0, 6'd0,  1'b0, 1'b0};
        tv[4]  = '{1'b0, 6'd0,  1'b0, 1'b0};
        tv[5]  = '{1'b0, 6'd0,  1'b0, 1'b0};
        tv[6]  = '{1'b0, 6'd0,  1'b0, 1'b1};
        tv[7]  = '{1'b1, 6'd0,  1'b1, 1'b1};
        tv[8]  = '{1'b0, 6'd0,  1'b1, 1'b1};
        tv[9]  = '{1'b0, 6'd0,  1'b1, 1'b1};
        tv[10] = '{1'b0, 6'd0,  1'b1, 1'b1};
        tv[11] = '{1'b1, 6'd37, 1'b0, 1'b1};
        tv[12] = '{1'b0, 6'd37, 1'b0, 1'b0};
        tv[13] = '{1'b0, 6'd37, 1'b0, 1'b1};
        tv[14] = '{1'b0, 6'd37, 1'b0, 1'b1};
        for (int i = 0; i < 15; i++) begin
            if (tv[i].do_start) do_start(tv[i].ch);
            bit_in = tv[i].b;
            bit_in_valid = 1'b1;
            tick;
            bit_in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), bit_out_valid, 1'b1);
            check($sformatf("vec%0d_bit", i), bit_out, tv[i].exp_out);
        end
        tick;
        check("valid_drop", bit_out_valid, 1'b0);

        // Length-0 advertising packet, channel 37
        pdu = {8'h02, 8'h00};
        build(6'd37, -1);
        ob = oct_q.size(); db = done_cnt;
        do_start(6'd37);
        check("busy_after_start", busy, 1'b1);
        send_pkt(0, 8'd0);
        repeat (3) tick;
        check_octets("len0", ob);
        check("len0_done_cnt", done_cnt - db, 1);
        check("len0_crc_ok", crc_ok, 1'b1);

        // Six-byte payload with a valid every third cycle
        pdu = {8'h02, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        build(6'd37, -1);
        ob = oct_q.size(); db = done_cnt;
        do_start(6'd37);
        send_pkt(2, 8'd6);
        repeat (3) tick;
        check_octets("len6", ob);
        check("len6_done_cnt", done_cnt - db, 1);
        check("len6_crc_ok", crc_ok, 1'b1);

        // Same packet, one payload bit flipped after CRC generation
        build(6'd37, 30);
        db = done_cnt;
        do_start(6'd37);
        send_pkt(0, 8'd6);
        repeat (3) tick;
        check("flip_done_cnt", done_cnt - db, 1);
        check("flip_crc_ok", crc_ok, 1'b0);

        // Abort at header bit 9, then a complete second packet
        pdu = {8'h02, 8'h00};
        build(6'd37, -1);
        db = done_cnt;
        do_start(6'd37);
        for (int i = 0; i < 9; i++) begin
            bit_in = bitq[i];
            bit_in_valid = 1'b1;
            tick;
        end
        pdu = {8'h45, 8'h00};
        build(6'd37, -1);
        bit_in = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        bit_in_valid = 1'b0;
        check("abort_plv_clear", payload_length_valid, 1'b0);
        ob = oct_q.size();
        send_pkt(1, 8'd0);
        repeat (3) tick;
        check_octets("abort", ob);
        check("abort_done_cnt", done_cnt - db, 1);
        check("abort_crc_ok", crc_ok, 1'b1);

        // Asynchronous reset mid-payload
        pdu = {8'h02, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        build(6'd37, -1);
        do_start(6'd37);
        for (int i = 0; i < 30; i++) begin
            bit_in = bitq[i];
            bit_in_valid = 1'b1;
            tick;
        end
        bit_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_bit_out_valid", bit_out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_plv", payload_length_valid, 1'b0);
        check("arst_payload_length", payload_length, 8'h00);
        check("arst_octet_out", octet_out, 8'h00);
        #2;
        rst_n = 1'b1;
        ob = oct_q.size(); db = done_cnt;
        for (int i = 0; i < 16; i++) begin
            bit_in = 1'b1;
            bit_in_valid = 1'b1;
            tick;
            bit_in_valid = 1'b0;
            if (bit_out_valid !== 1'b0) check("idle_bit_ignored", bit_out_valid, 1'b0);
        end
        tick;
        check("idle_no_octets", oct_q.size() - ob, 0);
        check("idle_busy", busy, 1'b0);
        check("idle_bit_out", bit_out, 1'b0);

        // Maximum payload length
        pdu = {8'h02, 8'hFF};
        for (int i = 0; i < 255; i++) pdu.push_back(8'(i * 7 + 3));
        build(6'd37, -1);
        ob = oct_q.size(); db = done_cnt;
        do_start(6'd37);
        send_pkt(0, 8'hFF);
        repeat (3) tick;
        check_octets("len255", ob);
        check("len255_done_cnt", done_cnt - db, 1);
        check("len255_crc_ok", crc_ok, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
